apb_slave: RTL and testbench

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_slave.sv | 122 ++++++++++++
 tb/tb_apb_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave.sv
// apb_slave: APB word-indexed register file, one wait state, registered responses.
// Rev 1.0
`default_nettype none

module apb_slave #(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic                 PREADY,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PSLVERR
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRWIDTH:0] LIMIT = DEPTH[ADDRWIDTH:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                 state;
  state_t                 next_state;
  logic                   do_latch;
  logic                   do_exec;
  logic                   idx_legal;
  logic [IDXW-1:0]        idx;
  logic [ADDRWIDTH-1:0]   lat_addr;
  logic                   lat_write;
  logic [DATAWIDTH-1:0]   lat_wdata;
  logic [DATAWIDTH-1:0]   mem [DEPTH];

  assign idx_legal = ({1'b0, lat_addr} < LIMIT);
  assign idx       = lat_addr[IDXW-1:0];

  always_comb begin
    next_state = state;
    do_latch   = 1'b0;
    do_exec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (PSEL && PENABLE) begin
          do_latch   = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PSEL && PENABLE) begin
          do_exec    = 1'b1;
          next_state = ST_RESP;
        end else begin
          next_state = ST_IDLE;
        end
      end
      // A still-asserted PENABLE parks in HOLD so one long access is one transfer.
      ST_RESP: next_state = PENABLE ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (!PENABLE) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
    end else if (do_latch) begin
      lat_addr  <= PADDR;
      lat_write <= PWRITE;
      lat_wdata <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      PREADY  <= do_exec;
      PSLVERR <= do_exec && !idx_legal;
      if (do_exec && !lat_write) begin
        PRDATA <= idx_legal ? mem[idx] : '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_exec && lat_write && idx_legal) begin
      mem[idx] <= lat_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed APB transfers against a transaction-level memory model.
// Rev 1.0
`default_nettype none

module tb_apb_slave;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  apb_slave #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PADDR  (PADDR),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PWDATA (PWDATA),
    .PREADY (PREADY),
    .PRDATA (PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Reference state: memory contents and what the outputs must show after the latest edge.
  logic [DW-1:0] model_mem [DEPTH];
  logic          exp_ready;
  logic          exp_err;
  logic [DW-1:0] exp_rdata;

  int  n_checks     = 0;
  int  n_fail       = 0;
  int  ready_pulses = 0;
  logic prev_ready  = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    check("pready", {31'b0, PREADY}, {31'b0, exp_ready});
    check("pslverr", {31'b0, PSLVERR}, {31'b0, exp_err});
    check("prdata", PRDATA, exp_rdata);
    if (PREADY === 1'b1 && prev_ready !== 1'b1) ready_pulses++;
    prev_ready = PREADY;
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic apply_outcome(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit legal;
    legal = (int'(addr) < DEPTH);
    if (wr && legal) model_mem[int'(addr)] = data;
    if (!wr) exp_rdata = legal ? model_mem[int'(addr)] : '0;
    exp_ready = 1'b1;
    exp_err   = !legal;
  endtask

  // Setup cycle, then en_edges edges with PSEL=PENABLE=1; bus inputs are scrambled after
  // the first enabled edge since the slave must act on what it latched there.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input int en_edges, input bit abort);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    step();
    PENABLE = 1'b1;
    step();
    PADDR = ~addr; PWDATA = ~data;
    if (abort) begin
      PENABLE = 1'b0;
      step();
      PSEL = 1'b0;
      step();
      return;
    end
    step();
    apply_outcome(wr, addr, data);
    for (int k = 2; k < en_edges; k++) begin
      step();
      exp_ready = 1'b0;
      exp_err   = 1'b0;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
    exp_ready = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Drives a transfer into its response cycle, then pulls reset between clock edges.
  task automatic reset_in_resp(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [DW-1:0] lit_rdata, input bit lit_err);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    step();
    PENABLE = 1'b1;
    step();
    step();
    apply_outcome(wr, addr, data);
    check("resp_before_rst_ready", {31'b0, PREADY}, 32'd1);
    check("resp_before_rst_err", {31'b0, PSLVERR}, {31'b0, lit_err});
    check("resp_before_rst_rdata", PRDATA, lit_rdata);
    #2;
    PRESET = 1'b0;
    clear_model();
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    check("rst_async_ready", {31'b0, PREADY}, 32'd0);
    check("rst_async_err", {31'b0, PSLVERR}, 32'd0);
    check("rst_async_rdata", PRDATA, 32'd0);
    step();
    step();
    PRESET = 1'b1;
    step();
  endtask

  initial begin
    int p0;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    clear_model();
    #1 PRESET = 1'b0;
    step();
    step();
    check("reset_ready", {31'b0, PREADY}, 32'd0);
    check("reset_rdata", PRDATA, 32'd0);
    PRESET = 1'b1;
    step();

    // Fill 0..9, then read back with one pulse per transfer.
    p0 = ready_pulses;
    for (int i = 0; i < 10; i++) xfer(1'b1, AW'(i), DW'(i), 2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      xfer(1'b0, AW'(i), 32'hDEAD_BEEF, 2, 1'b0);
      check("rd_lit", PRDATA, DW'(i));
    end
    check("pulses_20", DW'(ready_pulses - p0), 32'd20);

    xfer(1'b0, 8'd12, '0, 2, 1'b0);
    check("rd12_lit", PRDATA, 32'd0);

    // Index 20 would alias to 4 if the index were truncated.
    xfer(1'b1, 8'd20, 32'hA, 2, 1'b0);
    xfer(1'b0, 8'd20, '0, 2, 1'b0);
    check("rd20_lit", PRDATA, 32'd0);
    xfer(1'b0, 8'd4, '0, 2, 1'b0);
    check("rd4_lit", PRDATA, 32'd4);

    p0 = ready_pulses;
    xfer(1'b1, 8'd0, 32'hFF, 5, 1'b0);
    check("hold_one_pulse", DW'(ready_pulses - p0), 32'd1);
    xfer(1'b0, 8'd0, '0, 2, 1'b0);
    check("rd0_lit", PRDATA, 32'hFF);

    xfer(1'b1, 8'd2, 32'hF, 2, 1'b0);
    check("wr_keeps_rdata_1", PRDATA, 32'hFF);
    xfer(1'b1, 8'd2, 32'h5, 3, 1'b0);
    check("wr_keeps_rdata_2", PRDATA, 32'hFF);
    xfer(1'b0, 8'd2, '0, 2, 1'b0);
    check("rd2_lit", PRDATA, 32'h5);

    reset_in_resp(1'b0, 8'd2, '0, 32'h5, 1'b0);
    reset_in_resp(1'b1, 8'd200, 32'h1234, 32'h0, 1'b1);

    p0 = ready_pulses;
    xfer(1'b1, 8'd4, 32'h3, 2, 1'b1);
    check("abort_no_pulse", DW'(ready_pulses - p0), 32'd0);
    xfer(1'b0, 8'd4, '0, 2, 1'b0);
    check("abort_rd4_lit", PRDATA, 32'd0);
    xfer(1'b0, 8'd9, '0, 2, 1'b0);
    check("post_rst_rd9_lit", PRDATA, 32'd0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
